// File: rtl/wb_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_buf
// Purpose  : Writeback stage buffer. Selects the result source (ALU, load,
//            PC+4), aligns and sign/zero-extends load data, and queues
//            {rd,data} register-file writes in a DEPTH-entry FIFO. The FIFO
//            drains to the register-file write port under a valid/ready
//            handshake. Also provides a forwarding lookup into pending
//            writes and a count of accepted instructions.
// Ports    : clk           clock, rising edge
//            rst           asynchronous reset, active-low
//            i_valid       MEM stage presents an instruction
//            o_ready       stage can accept (registered, = not full)
//            i_we          instruction writes a register
//            i_wb_sel      00 ALU, 01 load, 10 PC+4, 11 ALU
//            i_ld_size     000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, else LW
//            i_addr_lo     low address bits of the load
//            i_mem_data    raw memory word
//            i_aluout_mem  ALU result
//            i_pc4         PC+4 link value
//            i_rd_mem      destination register
//            wb_ready      register file accepts the head write
//            WB_VALID      head entry valid
//            WB_DATA       {rd, data} of head entry
//            i_fwd_rs      register being read in decode
//            fwd_hit       a queued write to i_fwd_rs exists
//            fwd_data      data of youngest matching queued entry
//            RETIRE_CNT    instructions accepted since reset
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_buf #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_valid,
    output logic                      o_ready,
    input  wire logic                 i_we,
    input  wire logic [1:0]           i_wb_sel,
    input  wire logic [2:0]           i_ld_size,
    input  wire logic [1:0]           i_addr_lo,
    input  wire logic [XLEN-1:0]      i_mem_data,
    input  wire logic [XLEN-1:0]      i_aluout_mem,
    input  wire logic [XLEN-1:0]      i_pc4,
    input  wire logic [RAW-1:0]       i_rd_mem,
    input  wire logic                 wb_ready,
    output logic                      WB_VALID,
    output logic [RAW+XLEN-1:0]       WB_DATA,
    input  wire logic [RAW-1:0]       i_fwd_rs,
    output logic                      fwd_hit,
    output logic [XLEN-1:0]           fwd_data,
    output logic [CNT_W-1:0]          RETIRE_CNT
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_ENT_W = RAW + XLEN;
    localparam logic [c_OCC_W-1:0] c_FULL = c_OCC_W'(DEPTH);

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_ld;
    logic [XLEN-1:0]  w_res;

    // Byte lane selected by the full low address; halfword lane ignores
    // addr_lo[0] so a misaligned LH still returns an aligned halfword.
    assign w_byte = 8'(i_mem_data >> {i_addr_lo, 3'b000});
    assign w_half = 16'(i_mem_data >> {i_addr_lo[1], 4'b0000});

    always_comb begin
        w_ld = i_mem_data;
        case (i_ld_size)
            3'b000:  w_ld = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_ld = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_ld = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_ld = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld = i_mem_data;
        endcase
    end

    always_comb begin
        w_res = i_aluout_mem;
        case (i_wb_sel)
            2'b01:   w_res = w_ld;
            2'b10:   w_res = i_pc4;
            default: w_res = i_aluout_mem;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               r_ready;
    logic [c_ENT_W-1:0] r_wb_data;
    logic [CNT_W-1:0]   r_retire;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_PTR_W-1:0] w_wptr_nxt;
    logic [c_PTR_W-1:0] w_rptr_nxt;
    logic [c_OCC_W-1:0] w_occ_nxt;
    logic [c_OCC_W-1:0] w_occ_after_pop;
    logic [c_ENT_W-1:0] w_head_nxt;

    assign w_accept = i_valid & r_ready;
    // x0 is hard-wired zero, so writes to it are dropped at the door.
    assign w_push   = w_accept & i_we & (i_rd_mem != '0);
    assign w_pop    = WB_VALID & wb_ready;
    assign w_entry  = {i_rd_mem, w_res};

    assign w_wptr_nxt = w_push ? (r_wptr + c_PTR_W'(1)) : r_wptr;
    assign w_rptr_nxt = w_pop  ? (r_rptr + c_PTR_W'(1)) : r_rptr;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + c_OCC_W'(1);
            2'b01:   w_occ_nxt = r_occ - c_OCC_W'(1);
            default: w_occ_nxt = r_occ;
        endcase
    end

    // If nothing older survives this edge, the new head is the entry being
    // pushed right now (its storage slot is not written until the edge).
    assign w_occ_after_pop = w_pop ? (r_occ - c_OCC_W'(1)) : r_occ;
    assign w_head_nxt      = (w_occ_after_pop == '0) ? w_entry : r_mem[w_rptr_nxt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_ready   <= 1'b0;
            r_wb_data <= '0;
            r_retire  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
            end
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_occ   <= w_occ_nxt;
            // Ready is a registered !full, so a pop while full only reopens
            // the input on the following cycle.
            r_ready <= (w_occ_nxt != c_FULL);
            if (w_accept) begin
                r_retire <= r_retire + CNT_W'(1);
            end
            // Holding the head in a register keeps WB_DATA at its last value
            // once the FIFO runs empty.
            if (w_occ_nxt != '0) begin
                r_wb_data <= w_head_nxt;
            end
        end
    end

    assign o_ready    = r_ready;
    assign WB_VALID   = (r_occ != '0);
    assign WB_DATA    = r_wb_data;
    assign RETIRE_CNT = r_retire;

    // ------------------------------------------------------------------
    // Forwarding lookup: walk entries oldest to youngest so the youngest
    // match overwrites earlier ones. The head still counts while popping.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_OCC_W'(i) < r_occ) && (i_fwd_rs != '0) &&
                (r_mem[r_rptr + c_PTR_W'(i)][c_ENT_W-1:XLEN] == i_fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem[r_rptr + c_PTR_W'(i)][XLEN-1:0];
            end
        end
    end

endmodule
`default_nettype wire
